// File: rtl/usb_rx_deserializer_pkg.sv
// Shared types and constants for the USB receive bit path: line states, FSM
// encodings, PID fields and the CRC polynomials/residuals used by the checker.
package usb_rx_deserializer_pkg;

    localparam int PKT_MAX_BITS = 100;
    localparam int LEN_W        = $clog2(PKT_MAX_BITS + 1);

    typedef enum logic [1:0] {
        BUS_SE0 = 2'b00,
        BUS_K   = 2'b01,
        BUS_J   = 2'b10,
        BUS_SE1 = 2'b11
    } bus_state_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SYNC  = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_EOP1  = 3'd3;
    localparam logic [2:0] ST_EOP2  = 3'd4;
    localparam logic [2:0] ST_CHECK = 3'd5;
    localparam logic [2:0] ST_ERR   = 3'd6;

    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_SETUP = 8'h2D;
    localparam logic [7:0] PID_DATA0 = 8'hC3;

    localparam logic [1:0] PID_TYPE_TOKEN = 2'b01;
    localparam logic [1:0] PID_TYPE_DATA  = 2'b11;

    localparam logic [4:0]  CRC5_POLY      = 5'h05;
    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

endpackage

// File: rtl/usb_rx_crc_check.sv
// Serial CRC5/CRC16 residual checker fed with post-PID bits in wire order.
// Only present when USB_RX_CRC_CHECK_EN is defined.
`ifdef USB_RX_CRC_CHECK_EN
module usb_rx_crc_check
    import usb_rx_deserializer_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic bit_valid,
    input  logic bit_in,
    input  logic is_token,
    output logic residual_ok
);

    logic [4:0]  crc5_q;
    logic [15:0] crc16_q;
    logic        fb5;
    logic        fb16;

    assign fb5  = bit_in ^ crc5_q[4];
    assign fb16 = bit_in ^ crc16_q[15];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            crc5_q  <= '1;
            crc16_q <= '1;
        end else if (clear) begin
            crc5_q  <= '1;
            crc16_q <= '1;
        end else if (bit_valid) begin
            crc5_q  <= {crc5_q[3:0], 1'b0} ^ (fb5 ? CRC5_POLY : 5'h00);
            crc16_q <= {crc16_q[14:0], 1'b0} ^ (fb16 ? CRC16_POLY : 16'h0000);
        end
    end

    // Feeding the transmitted (inverted) CRC through the register leaves a fixed residual.
    assign residual_ok = is_token ? (crc5_q == CRC5_RESIDUAL) : (crc16_q == CRC16_RESIDUAL);

endmodule
`endif

// File: rtl/usb_rx_deserializer.sv
// USB receive bit path: SYNC detect, NRZI decode, unstuff, EOP detect, packet check.
// Define USB_RX_CRC_CHECK_EN to add the token/data CRC residual check in CHECK.
module usb_rx_deserializer
    import usb_rx_deserializer_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    DP,
    input  logic                    DM,
    input  logic                    rx_enable,
    output logic [PKT_MAX_BITS-1:0] pkt_out,
    output logic [31:0]             pkt_len,
    output logic                    pkt_valid,
    output logic                    rx_error,
    output logic                    rx_busy
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PKT_MAX_BITS);
    localparam logic [LEN_W-1:0] LEN_PID = LEN_W'(8);

    bus_state_t             line_p0;
    bus_state_t             prev_q;
    logic [2:0]             state_q, state_d;
    logic [2:0]             zcnt_q, zcnt_d;
    logic [2:0]             ones_q, ones_d;
    logic [2:0]             jcnt_q, jcnt_d;
    logic [LEN_W-1:0]       len_q;
    logic [PKT_MAX_BITS-1:0] pkt_q;
    logic                   err_pulse_q;
    logic                   is_jk;
    logic                   bit_d;
    logic                   clr;
    logic                   wr_en;
    logic                   crc_ok;
    logic                   pass;
    logic                   in_check;

    // Stage p0: input register on the raw line.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) line_p0 <= BUS_J;
        else       line_p0 <= bus_state_t'({DP, DM});
    end

    assign is_jk = (line_p0 == BUS_J) || (line_p0 == BUS_K);
    assign bit_d = (line_p0 == prev_q);

    always_comb begin
        state_d = state_q;
        zcnt_d  = zcnt_q;
        ones_d  = ones_q;
        jcnt_d  = jcnt_q;
        clr     = 1'b0;
        wr_en   = 1'b0;
        if (!rx_enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (line_p0 == BUS_K) begin
                        state_d = ST_SYNC;
                        zcnt_d  = 3'd1;
                    end
                end
                ST_SYNC: begin
                    if (!is_jk) begin
                        state_d = ST_IDLE;
                    end else if (!bit_d) begin
                        if (zcnt_q == 3'd7) state_d = ST_IDLE;
                        else                zcnt_d  = zcnt_q + 3'd1;
                    end else if (zcnt_q == 3'd7) begin
                        state_d = ST_DATA;
                        clr     = 1'b1;
                        ones_d  = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    case (line_p0)
                        BUS_SE0: state_d = ST_EOP1;
                        BUS_SE1: state_d = ST_ERR;
                        default: begin
                            // After six 1s the next bit must be the stuffed 0.
                            if (ones_q == 3'd6) begin
                                if (bit_d) state_d = ST_ERR;
                                else       ones_d  = 3'd0;
                            end else if (len_q == LEN_MAX) begin
                                state_d = ST_ERR;
                            end else begin
                                wr_en  = 1'b1;
                                ones_d = bit_d ? ones_q + 3'd1 : 3'd0;
                            end
                        end
                    endcase
                end
                ST_EOP1:  state_d = (line_p0 == BUS_SE0) ? ST_EOP2 : ST_ERR;
                ST_EOP2:  state_d = (line_p0 == BUS_J) ? ST_CHECK : ST_ERR;
                ST_CHECK: state_d = ST_IDLE;
                ST_ERR: begin
                    if (line_p0 == BUS_J) begin
                        if (jcnt_q == 3'd7) state_d = ST_IDLE;
                        else                jcnt_d  = jcnt_q + 3'd1;
                    end else begin
                        jcnt_d = 3'd0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        if ((state_d == ST_ERR) && (state_q != ST_ERR)) jcnt_d = 3'd0;
    end

    // Stage p1: FSM, packet assembly and error pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            prev_q      <= BUS_J;
            zcnt_q      <= 3'd0;
            ones_q      <= 3'd0;
            jcnt_q      <= 3'd0;
            len_q       <= '0;
            pkt_q       <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            zcnt_q      <= zcnt_d;
            ones_q      <= ones_d;
            jcnt_q      <= jcnt_d;
            err_pulse_q <= (state_d == ST_ERR) && (state_q != ST_ERR);
            if (state_d == ST_IDLE) prev_q <= BUS_J;
            else if (is_jk)         prev_q <= line_p0;
            if (clr) begin
                pkt_q <= '0;
                len_q <= '0;
            end else if (wr_en) begin
                pkt_q[len_q] <= bit_d;
                len_q        <= len_q + LEN_W'(1);
            end
        end
    end

`ifdef USB_RX_CRC_CHECK_EN
    logic crc_bit_valid;
    logic is_token;
    logic is_data;
    logic residual_ok;

    assign crc_bit_valid = wr_en && (len_q >= LEN_PID);
    assign is_token      = (pkt_q[1:0] == PID_TYPE_TOKEN);
    assign is_data       = (pkt_q[1:0] == PID_TYPE_DATA);

    usb_rx_crc_check u_crc (
        .clock       (clock),
        .reset       (reset),
        .clear       (clr),
        .bit_valid   (crc_bit_valid),
        .bit_in      (bit_d),
        .is_token    (is_token),
        .residual_ok (residual_ok)
    );

    assign crc_ok = (is_token || is_data) ? residual_ok : 1'b1;
`else
    assign crc_ok = 1'b1;
`endif

    assign pass     = (len_q >= LEN_PID) && (pkt_q[7:4] == ~pkt_q[3:0]) && crc_ok;
    assign in_check = (state_q == ST_CHECK) && rx_enable;

    assign pkt_out   = pkt_q;
    assign pkt_len   = {{(32 - LEN_W){1'b0}}, len_q};
    assign pkt_valid = in_check && pass;
    assign rx_error  = err_pulse_q || (in_check && !pass);
    assign rx_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_usb_rx_deserializer.sv
// Directed bench for usb_rx_deserializer: encodes packets onto DP/DM (SYNC,
// stuffing, NRZI, EOP) and checks received packets, errors and latencies.
module tb_usb_rx_deserializer;
    import usb_rx_deserializer_pkg::*;

    localparam logic [1:0] LJ   = 2'b10;
    localparam logic [1:0] LK   = 2'b01;
    localparam logic [1:0] LSE0 = 2'b00;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic DP = 1'b1;
    logic DM = 1'b0;
    logic rx_enable = 1'b1;
    logic [PKT_MAX_BITS-1:0] pkt_out;
    logic [31:0] pkt_len;
    logic pkt_valid, rx_error, rx_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int drv_cyc = 0;
    int eop_cyc = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int valid_cyc = 0;
    int err_cyc = 0;
    logic [31:0] cap_len = '0;
    logic [1:0] nrzi_st = 2'b01;
    int ones = 0;

    always #5 clock = ~clock;

    usb_rx_deserializer dut (
        .clock     (clock),
        .reset     (reset),
        .DP        (DP),
        .DM        (DM),
        .rx_enable (rx_enable),
        .pkt_out   (pkt_out),
        .pkt_len   (pkt_len),
        .pkt_valid (pkt_valid),
        .rx_error  (rx_error),
        .rx_busy   (rx_busy)
    );

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (pkt_valid) begin
            valid_cnt <= valid_cnt + 1;
            valid_cyc <= cyc;
            cap_len   <= pkt_len;
        end
        if (rx_error) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sym(input logic [1:0] s);
        @(posedge clock);
        #1;
        {DP, DM} = s;
        drv_cyc = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) sym(LJ);
    endtask

    task automatic send_sync();
        sym(LK); sym(LJ); sym(LK); sym(LJ);
        sym(LK); sym(LJ); sym(LK); sym(LK);
        nrzi_st = LK;
        ones = 0;
    endtask

    task automatic send_bit(input logic b, input logic stuff);
        if (!b) nrzi_st = ~nrzi_st;
        sym(nrzi_st);
        if (stuff) begin
            if (b) ones++;
            else   ones = 0;
            if (ones == 6) begin
                nrzi_st = ~nrzi_st;
                sym(nrzi_st);
                ones = 0;
            end
        end
    endtask

    task automatic send_eop();
        sym(LSE0);
        sym(LSE0);
        sym(LJ);
        eop_cyc = drv_cyc;
    endtask

    task automatic send_pkt(input logic [127:0] bits, input int n);
        send_sync();
        for (int i = 0; i < n; i++) send_bit(bits[i], 1'b1);
        send_eop();
        idle(4);
    endtask

    task automatic expect_good(input string tag, input logic [127:0] bits, input int n,
                               input int v0, input int e0);
        check({tag, "_valid_pulses"}, 128'(valid_cnt - v0), 128'(1));
        check({tag, "_error_pulses"}, 128'(err_cnt - e0), 128'(0));
        check({tag, "_len"}, 128'(cap_len), 128'(n));
        check({tag, "_pkt_out"}, 128'(pkt_out), bits);
        check({tag, "_latency"}, 128'(valid_cyc - eop_cyc), 128'(2));
    endtask

    task automatic expect_bad(input string tag, input int ref_cyc, input int v0, input int e0);
        check({tag, "_error_pulses"}, 128'(err_cnt - e0), 128'(1));
        check({tag, "_valid_pulses"}, 128'(valid_cnt - v0), 128'(0));
        check({tag, "_err_latency"}, 128'(err_cyc - ref_cyc), 128'(2));
    endtask

    function automatic logic [31:0] data0_bits();
        logic [15:0] crc;
        logic [7:0]  payload;
        logic [31:0] r;
        logic        fb;
        crc     = 16'hFFFF;
        payload = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            fb  = payload[i] ^ crc[15];
            crc = {crc[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
        end
        r[7:0]  = PID_DATA0;
        r[15:8] = payload;
        for (int k = 0; k < 16; k++) r[16 + k] = ~crc[15 - k];
        return r;
    endfunction

    initial begin
        int v0, e0, ref_cyc;
        logic [31:0] d0;

        idle(3);
        check("reset_pkt_out", 128'(pkt_out), 128'(0));
        check("reset_pkt_len", 128'(pkt_len), 128'(0));
        check("reset_pkt_valid", 128'(pkt_valid), 128'(0));
        check("reset_rx_error", 128'(rx_error), 128'(0));
        check("reset_rx_busy", 128'(rx_busy), 128'(0));
        reset = 1'b0;
        idle(3);

        v0 = valid_cnt; e0 = err_cnt;
        send_pkt(128'hD2, 8);
        expect_good("ack", 128'hD2, 8, v0, e0);

        v0 = valid_cnt; e0 = err_cnt;
        send_pkt(128'h10002D, 24);
        expect_good("setup", 128'h10002D, 24, v0, e0);

        v0 = valid_cnt; e0 = err_cnt;
        send_pkt(128'h90002D, 24);
`ifdef USB_RX_CRC_CHECK_EN
        expect_bad("setup_badcrc", eop_cyc, v0, e0);
`else
        expect_good("setup_badcrc", 128'h90002D, 24, v0, e0);
`endif

        d0 = data0_bits();
        v0 = valid_cnt; e0 = err_cnt;
        send_pkt(128'(d0), 32);
        expect_good("data0", 128'(d0), 32, v0, e0);
        check("data0_payload", 128'(pkt_out[15:8]), 128'hFF);

        // Seven unstuffed 1s right after SYNC.
        v0 = valid_cnt; e0 = err_cnt;
        send_sync();
        for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
        ref_cyc = drv_cyc;
        idle(6);
        check("stuff_err_busy_in_err", 128'(rx_busy), 128'(1));
        idle(4);
        check("stuff_err_idle_after_j", 128'(rx_busy), 128'(0));
        expect_bad("stuff_err", ref_cyc, v0, e0);

        v0 = valid_cnt; e0 = err_cnt;
        send_pkt(128'hD2, 100);
        expect_good("len100", 128'hD2, 100, v0, e0);

        v0 = valid_cnt; e0 = err_cnt;
        send_sync();
        for (int i = 0; i < 101; i++) send_bit(i < 8 ? PID_ACK[i] : 1'b0, 1'b1);
        ref_cyc = drv_cyc;
        send_eop();
        idle(12);
        expect_bad("overflow", ref_cyc, v0, e0);
        check("overflow_idle", 128'(rx_busy), 128'(0));

        v0 = valid_cnt; e0 = err_cnt;
        send_pkt(128'hD3, 8);
        expect_bad("bad_pid", eop_cyc, v0, e0);

        v0 = valid_cnt; e0 = err_cnt;
        send_sync();
        for (int i = 0; i < 7; i++) send_bit(PID_ACK[i], 1'b1);
        check("midpkt_busy", 128'(rx_busy), 128'(1));
        check("midpkt_len", 128'(pkt_len), 128'(5));
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_pkt_out", 128'(pkt_out), 128'(0));
        check("async_reset_pkt_len", 128'(pkt_len), 128'(0));
        check("async_reset_pkt_valid", 128'(pkt_valid), 128'(0));
        check("async_reset_rx_error", 128'(rx_error), 128'(0));
        check("async_reset_rx_busy", 128'(rx_busy), 128'(0));
        idle(3);
        reset = 1'b0;
        idle(4);
        check("reset_no_valid", 128'(valid_cnt - v0), 128'(0));
        check("reset_no_error", 128'(err_cnt - e0), 128'(0));

        v0 = valid_cnt; e0 = err_cnt;
        send_pkt(128'hD2, 8);
        expect_good("ack_after_reset", 128'hD2, 8, v0, e0);

        v0 = valid_cnt; e0 = err_cnt;
        send_sync();
        for (int i = 0; i < 4; i++) send_bit(PID_ACK[i], 1'b1);
        rx_enable = 1'b0;
        sym(LJ);
        check("disable_busy", 128'(rx_busy), 128'(0));
        idle(6);
        rx_enable = 1'b1;
        idle(4);
        check("disable_no_valid", 128'(valid_cnt - v0), 128'(0));
        check("disable_no_error", 128'(err_cnt - e0), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
